operand_loader: RTL

- Data-side counterpart of the load/result control unit.
- The control unit drives `loaddata`. This block answers by capturing NUM_OPS operands from a shared input bus, one per rising edge of a user strobe (pushbutton/switch).
- Once all operands are captured it asserts `inputdata_ready`. It then holds the assembled operands stable for the datapath until the next load request.

---
 rtl/operand_loader_if.sv | 28 ++
 rtl/operand_loader.sv | 124 ++++++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// operand_loader_if: groups the load-request, operand-bus and status signals of the operand loader.
// Latency: none, wires only.
// Backpressure: none; the loader has no stall path toward the user or the datapath.
// Ports: master = control/user side (drives loaddata, data_in, data_strobe),
//        slave  = operand_loader (drives inputdata_ready, capture_ack, op_index, operands).
interface operand_loader_if #(
   parameter int DATA_W  = 8,
   parameter int NUM_OPS = 2,
   parameter int IDX_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
);
   logic                        loaddata;
   logic [DATA_W-1:0]           data_in;
   logic                        data_strobe;
   logic                        inputdata_ready;
   logic                        capture_ack;
   logic [IDX_W-1:0]            op_index;
   logic [DATA_W*NUM_OPS-1:0]   operands;

   modport master (
      output loaddata, data_in, data_strobe,
      input  inputdata_ready, capture_ack, op_index, operands
   );

   modport slave (
      input  loaddata, data_in, data_strobe,
      output inputdata_ready, capture_ack, op_index, operands
   );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: captures NUM_OPS operands from data_in, one per rising edge of data_strobe, per load request.
// Latency: capture on the clock edge seeing the strobe edge; ack/op_index/operands/ready visible the next cycle.
// Backpressure: none; strobe edges outside CAPTURE are dropped, operands stay frozen until the next loaddata.
// Optional macro OPERAND_LOADER_SYNC_EN: data_strobe passes a 2-flop synchronizer (+2 cycles capture latency).
// Ports: clk, reset_n (async, active-low); bus (operand_loader_if.slave):
//        loaddata, data_in, data_strobe in; inputdata_ready, capture_ack, op_index, operands out.
module operand_loader #(
   parameter int DATA_W  = 8,
   parameter int NUM_OPS = 2,
   parameter int IDX_W   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
   input  logic            clk,
   input  logic            reset_n,
   operand_loader_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_READY   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

   state_t                     state;
   logic                       strobe_s;     // strobe as seen by the edge detector
   logic                       strobe_q;
   logic                       strobe_edge;
   logic                       ready_q;
   logic                       ack_q;
   logic [IDX_W-1:0]           idx_q;
   logic [DATA_W*NUM_OPS-1:0]  ops_q;

`ifdef OPERAND_LOADER_SYNC_EN
   // The strobe comes from a switch/pushbutton, so bring it into clk before use.
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], bus.data_strobe};
      end
   end

   assign strobe_s = sync_q[1];
`else
   assign strobe_s = bus.data_strobe;
`endif

   // strobe_q tracks the strobe in every state, so a strobe already high when
   // CAPTURE is entered produces no edge there.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= strobe_s;
      end
   end

   assign strobe_edge = strobe_s & ~strobe_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         idx_q   <= '0;
         ops_q   <= '0;
      end else begin
         ack_q <= 1'b0;
         case (state)
            S_IDLE: begin
               ready_q <= 1'b0;
               if (bus.loaddata) begin
                  state <= S_CAPTURE;
                  idx_q <= '0;
               end
            end
            S_CAPTURE: begin
               // Abort wins over a simultaneous edge; captured slots are kept.
               if (!bus.loaddata) begin
                  state <= S_IDLE;
                  idx_q <= '0;
               end else if (strobe_edge) begin
                  ops_q[int'(idx_q)*DATA_W +: DATA_W] <= bus.data_in;
                  ack_q <= 1'b1;
                  if (idx_q == LAST_IDX) begin
                     state   <= S_READY;
                     ready_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + IDX_W'(1);
                  end
               end
            end
            S_READY: begin
               ready_q <= 1'b1;
               if (!bus.loaddata) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.loaddata) begin
                  state   <= S_CAPTURE;
                  ready_q <= 1'b0;
                  idx_q   <= '0;
               end
            end
            default: begin
               state   <= S_IDLE;
               ready_q <= 1'b0;
               idx_q   <= '0;
            end
         endcase
      end
   end

   assign bus.inputdata_ready = ready_q;
   assign bus.capture_ack     = ack_q;
   assign bus.op_index        = idx_q;
   assign bus.operands        = ops_q;

endmodule
